// File: rtl/sync_debounce_edge.sv
// Debouncer for an already-synchronized 1-bit level: a new level is accepted after
// DEBOUNCE_CYCLES consecutive qualified samples, with registered rise/fall pulses.
module sync_debounce_edge #(
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic RESET_LEVEL     = 1'b0,
   parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din_sync,
   input  logic sample_en,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic busy_o
);

   typedef enum logic [1:0] {
      ST_LOW,
      ST_LOW_CHK,
      ST_HIGH,
      ST_HIGH_CHK
   } state_t;

   localparam state_t           RESET_STATE = RESET_LEVEL ? ST_HIGH : ST_LOW;
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic             ONE_SHOT    = (DEBOUNCE_CYCLES == 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             level_nxt;
   logic             rise_nxt;
   logic             fall_nxt;

   // Any opposite sample in a CHK state drops back to the stable state and restarts the count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level_o;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      if (sample_en) begin
         case (state)
            ST_LOW: begin
               if (din_sync) begin
                  if (ONE_SHOT) begin
                     state_nxt = ST_HIGH;
                     cnt_nxt   = '0;
                     level_nxt = 1'b1;
                     rise_nxt  = 1'b1;
                  end else begin
                     state_nxt = ST_LOW_CHK;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            ST_LOW_CHK: begin
               if (!din_sync) begin
                  state_nxt = ST_LOW;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = ST_HIGH;
                  cnt_nxt   = '0;
                  level_nxt = 1'b1;
                  rise_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_HIGH: begin
               if (!din_sync) begin
                  if (ONE_SHOT) begin
                     state_nxt = ST_LOW;
                     cnt_nxt   = '0;
                     level_nxt = 1'b0;
                     fall_nxt  = 1'b1;
                  end else begin
                     state_nxt = ST_HIGH_CHK;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            ST_HIGH_CHK: begin
               if (din_sync) begin
                  state_nxt = ST_HIGH;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = ST_LOW;
                  cnt_nxt   = '0;
                  level_nxt = 1'b0;
                  fall_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = RESET_STATE;
               cnt_nxt   = '0;
               level_nxt = RESET_LEVEL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= RESET_STATE;
         cnt     <= '0;
         level_o <= RESET_LEVEL;
         rise_o  <= 1'b0;
         fall_o  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         level_o <= level_nxt;
         rise_o  <= rise_nxt;
         fall_o  <= fall_nxt;
      end
   end

   assign busy_o = (state == ST_LOW_CHK) || (state == ST_HIGH_CHK);

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: three instances (N=4, N=1, N=8/RESET_LEVEL=1) share stimulus
// and are compared against a run-length reference model plus hand-written vectors.
module tb_sync_debounce_edge;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       din_sync;
   logic       sample_en;
   logic [2:0] level;
   logic [2:0] rise;
   logic [2:0] fall;
   logic [2:0] busy;

   int tests_run    = 0;
   int tests_failed = 0;

   int   model_n[3]  = '{4, 1, 8};
   logic model_rl[3] = '{1'b0, 1'b0, 1'b1};
   logic m_level[3];
   logic m_rise[3];
   logic m_fall[3];
   int   m_run[3];

   typedef struct {
      logic din;
      logic en;
      int   exp;
   } vec_t;

   vec_t tbl[13];

   always #5 clk = ~clk;

   sync_debounce_edge #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .din_sync(din_sync), .sample_en(sample_en),
      .level_o(level[0]), .rise_o(rise[0]), .fall_o(fall[0]), .busy_o(busy[0]));

   sync_debounce_edge #(.DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) dut1 (
      .clk(clk), .reset_n(reset_n), .din_sync(din_sync), .sample_en(sample_en),
      .level_o(level[1]), .rise_o(rise[1]), .fall_o(fall[1]), .busy_o(busy[1]));

   sync_debounce_edge #(.DEBOUNCE_CYCLES(8), .RESET_LEVEL(1'b1)) dut2 (
      .clk(clk), .reset_n(reset_n), .din_sync(din_sync), .sample_en(sample_en),
      .level_o(level[2]), .rise_o(rise[2]), .fall_o(fall[2]), .busy_o(busy[2]));

   task automatic checkOutput(input string name, input int act, input int exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int dutVec(input int i);
      return int'({level[i], rise[i], fall[i], busy[i]});
   endfunction

   function automatic int modelVec(input int i);
      return int'({m_level[i], m_rise[i], m_fall[i], (m_run[i] != 0)});
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         m_level[i] = model_rl[i];
         m_rise[i]  = 1'b0;
         m_fall[i]  = 1'b0;
         m_run[i]   = 0;
      end
   endtask

   // Reference: count consecutive qualified samples that differ from the accepted level.
   task automatic modelStep(input logic din, input logic en);
      for (int i = 0; i < 3; i++) begin
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         if (en) begin
            if (din != m_level[i]) begin
               m_run[i]++;
               if (m_run[i] == model_n[i]) begin
                  m_level[i] = din;
                  m_rise[i]  = din;
                  m_fall[i]  = !din;
                  m_run[i]   = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
   endtask

   task automatic checkModel(input string tag);
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("%s inst%0d {level,rise,fall,busy}", tag, i), dutVec(i), modelVec(i));
   endtask

   task automatic applyStimulus(input logic din, input logic en);
      din_sync  = din;
      sample_en = en;
      @(posedge clk);
      modelStep(din, en);
      #1;
      checkModel("model");
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      #1;
      modelReset();
      checkModel("reset");
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      int   first_rise;
      int   pulses;
      logic rdin;

      tbl[0]  = '{1'b1, 1'b1, 4'b0001};
      tbl[1]  = '{1'b1, 1'b1, 4'b0001};
      tbl[2]  = '{1'b1, 1'b1, 4'b0001};
      tbl[3]  = '{1'b1, 1'b1, 4'b1100};
      tbl[4]  = '{1'b1, 1'b1, 4'b1000};
      tbl[5]  = '{1'b0, 1'b1, 4'b1001};
      tbl[6]  = '{1'b0, 1'b0, 4'b1001};
      tbl[7]  = '{1'b1, 1'b1, 4'b1000};
      tbl[8]  = '{1'b0, 1'b1, 4'b1001};
      tbl[9]  = '{1'b0, 1'b1, 4'b1001};
      tbl[10] = '{1'b0, 1'b1, 4'b1001};
      tbl[11] = '{1'b0, 1'b1, 4'b0010};
      tbl[12] = '{1'b0, 1'b1, 4'b0000};

      reset_n   = 1'b1;
      din_sync  = 1'b0;
      sample_en = 1'b0;
      #1;
      doReset();
      checkOutput("reset inst0 const", dutVec(0), 4'b0000);
      checkOutput("reset inst2 const", dutVec(2), 4'b1000);

      // N=4 rise latency, gated hold, restart and fall
      for (int k = 0; k < 13; k++) begin
         applyStimulus(tbl[k].din, tbl[k].en);
         checkOutput($sformatf("table step %0d inst0", k), dutVec(0), tbl[k].exp);
      end

      // Bounce shorter than N never accepted
      pulses = 0;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b1);
            pulses += int'(rise[0]) + int'(fall[0]);
         end
         applyStimulus(1'b0, 1'b1);
         pulses += int'(rise[0]) + int'(fall[0]);
      end
      checkOutput("bounce inst0 level", int'(level[0]), 0);
      checkOutput("bounce inst0 pulses", pulses, 0);

      // Sparse sample_en: qualified samples on cycles 1,4,7,10
      first_rise = 0;
      for (int c = 1; c <= 15; c++) begin
         applyStimulus(1'b1, ((c - 1) % 3) == 0);
         if (rise[0] && first_rise == 0) first_rise = c;
      end
      checkOutput("sparse enable rise cycle", first_rise, 10);

      // N=1 registered pass-through (inst1 currently high)
      applyStimulus(1'b0, 1'b1);
      checkOutput("n1 fall", dutVec(1), 4'b0010);
      applyStimulus(1'b1, 1'b1);
      checkOutput("n1 rise", dutVec(1), 4'b1100);
      applyStimulus(1'b0, 1'b0);
      checkOutput("n1 gated hold", dutVec(1), 4'b1000);

      // N=8, RESET_LEVEL=1: async reset mid-count then a full run is needed
      doReset();
      for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b1);
      checkOutput("n8 counting busy", int'(busy[2]), 1);
      reset_n = 1'b0;
      #1;
      checkOutput("n8 async reset {level,busy}", int'({level[2], busy[2]}), 2'b10);
      checkOutput("n8 async reset pulses", int'({rise[2], fall[2]}), 0);
      modelReset();
      #1;
      reset_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 7; c++) begin
         applyStimulus(1'b0, 1'b1);
         pulses += int'(fall[2]);
      end
      checkOutput("n8 no early fall", pulses, 0);
      checkOutput("n8 level held", int'(level[2]), 1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("n8 fall on 8th", int'({level[2], fall[2]}), 2'b01);

      // Random stimulus against the model
      doReset();
      rdin = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         if ($urandom_range(0, 15) == 0) rdin = ~rdin;
         applyStimulus(rdin, $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
